serial_dl11: RTL and testbench
==============================

// Module: serial_dl11
// PURPOSE
//  DL11-style console register file between the CPU bus and the UART pair (serial_rx / serial_tx).
//  Drains received bytes into a small FIFO and exposes RCSR/RBUF/XCSR/XBUF.
//  Sequences transmit bytes into serial_tx and raises level interrupt requests.
// PARAMETERS
//  RXF_AW  2  rx FIFO address width; depth = 2**RXF_AW (default 4 bytes)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-low reset
//  sel        in   1   register window selected
//  addr       in   2   register index (bus addr[2:1]): 0 RCSR, 1 RBUF, 2 XCSR, 3 XBUF
//  wr         in   1   write strobe, one-cycle pulse, qualified by sel
//  rd         in   1   read strobe, one-cycle pulse, qualified by sel
//  wdata      in   16  write data
//  rdata      out  16  read data, combinational from addr
//  rx_byte    in   8   received byte from serial_rx
//  rx_ready   in   1   serial_rx byte-valid; held until acknowledged
//  rx_read    out  1   one-cycle acknowledge to serial_rx
//  tx_byte    out  8   byte to serial_tx
//  tx_send    out  1   one-cycle start pulse to serial_tx
//  tx_busy    in   1   serial_tx busy; rises 2 clk after tx_send
//  rx_irq     out  1   receive interrupt request (level)
//  tx_irq     out  1   transmit interrupt request (level)
// BEHAVIOUR
//  Reset: FIFO empty, RIE=XIE=0, OVR=0, XREADY=1, tx FSM IDLE;
//   rx_read=0, tx_send=0, tx_byte=0, rx_irq=0, tx_irq=0.
//  RCSR read: {8'b0, DONE, RIE, 6'b0}; DONE = FIFO not empty. Write sets RIE=wdata[6].
//  RBUF read: {OVR, OVR, 6'b0, FIFO head}; head reads 0 when empty.
//   rd on RBUF pops one entry if not empty and clears OVR (empty-FIFO read still clears OVR).
//   RBUF writes are ignored.
//  XCSR read: {8'b0, XREADY, XIE, 6'b0}. Write sets XIE=wdata[6].
//  XBUF read: 0. A write while XREADY=1 latches wdata[7:0] and clears XREADY.
//   A write while XREADY=0 is ignored.
//  Rx capture: rx_ready=1 and rx_read=0 on the previous cycle gives a capture.
//   rx_read pulses 1 cycle and the byte is pushed to the FIFO.
//   rx_read is never asserted on two consecutive cycles, so no double capture.
//  Overrun: capture with FIFO full and no same-cycle pop -> byte dropped, OVR=1 (sticky); rx_read still pulses.
//   Capture with FIFO full and same-cycle RBUF pop -> push and pop both happen, no overrun.
//  FIFO pointers are RXF_AW+1 bits and wrap modulo 2**(RXF_AW+1); full = addresses equal, MSBs differ.
//  Tx FSM:
//   IDLE: XREADY=0 and byte pending -> SEND.
//   SEND: tx_send=1 for one cycle, tx_byte=latched byte -> WAITB.
//   WAITB: tx_busy=1 -> WAITD.
//   WAITD: tx_busy=0 -> XREADY=1, IDLE.
//   tx_byte holds its value outside SEND.
//  rx_irq = RIE & DONE. tx_irq = XIE & XREADY. Both registered, so 1 cycle lag.
//  Reset mid-operation: all state returns to reset values at once.
//   An in-flight serial_tx frame is not aborted here; the FSM restarts in IDLE.
//   A rx_ready still pending after reset is captured normally.
// TESTING
//  1. Reset: rdata at RCSR=0x0000, XCSR=0x0080; rx_irq=0, tx_irq=0.
//  2. rx_ready with rx_byte=0x41, held until rx_read -> exactly one rx_read pulse.
//     RCSR reads 0x0080, RBUF reads 0x0041; after RBUF rd, RCSR=0x0000.
//  3. Push 5 bytes 0x01..0x05 with no reads -> 5th dropped, RBUF reads 0xC001.
//     Next reads give 0x0002, 0x0003, 0x0004, then RCSR=0x0000.
//  4. XIE=1, write XBUF=0x5A -> XCSR=0x0040, tx_irq=0, one tx_send with tx_byte=0x5A.
//     A second XBUF write during busy is ignored. After tx_busy falls: XCSR=0x00C0, tx_irq=1.
//  5. FIFO full, capture and RBUF rd in the same cycle -> OVR stays 0, count stays 4.
//  6. Assert reset during WAITB and during a pending rx_ready -> all outputs return to reset values.
//     After release, the pending byte is captured once.

Source files
------------

// File: rtl/serial_dl11.sv
// serial_dl11 -- DL11-style console register file.
//
// Sits between the CPU bus and a serial_rx / serial_tx UART pair. Bytes
// coming from serial_rx are drained into a small FIFO. The CPU sees the
// four classic registers RCSR / RBUF / XCSR / XBUF. Transmit bytes are
// handed to serial_tx by a small sequencer. Level interrupt requests are
// raised for receive-done and transmit-ready.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   sel, addr, wr, rd   register window select, index (0 RCSR, 1 RBUF,
//                       2 XCSR, 3 XBUF), one-cycle write / read strobes
//   wdata, rdata        write data, read data (combinational from addr)
//   rx_byte, rx_ready   byte and byte-valid from serial_rx
//   rx_read             one-cycle acknowledge to serial_rx
//   tx_byte, tx_send    byte and one-cycle start pulse to serial_tx
//   tx_busy             serial_tx busy indication
//   rx_irq, tx_irq      registered level interrupt requests
module serial_dl11 #(
  parameter int RXF_AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        wr,
  input  logic        rd,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic        rx_read,
  output logic [7:0]  tx_byte,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic        rx_irq,
  output logic        tx_irq
);

  localparam int DEPTH = 2 ** RXF_AW;
  localparam logic [RXF_AW:0] PTR_ONE = {{RXF_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAITB = 2'd2,
    WAITD = 2'd3
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [7:0]      fifo_mem_r [DEPTH];
  logic [RXF_AW:0] wptr_r;
  logic [RXF_AW:0] rptr_r;
  logic            ovr_r;
  logic            rie_r;
  logic            xie_r;
  logic            xready_r;
  logic            pending_r;
  logic [7:0]      xbuf_r;
  logic            rx_read_r;
  logic            tx_send_r;
  logic [7:0]      tx_byte_r;
  logic            rx_irq_r;
  logic            tx_irq_r;
  tx_state_t       state_r;
  tx_state_t       next_state_s;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       empty_s;
  logic       full_s;
  logic [7:0] head_s;
  logic       rcsr_wr_s;
  logic       xcsr_wr_s;
  logic       xbuf_wr_s;
  logic       rbuf_rd_s;
  logic       pop_s;
  logic       capture_s;
  logic       push_s;
  logic       overrun_s;
  logic       unused_bits_s;

  assign empty_s = (wptr_r == rptr_r);
  // Same slot but opposite lap bit: the writer is a full lap ahead.
  assign full_s  = (wptr_r[RXF_AW-1:0] == rptr_r[RXF_AW-1:0]) &&
                   (wptr_r[RXF_AW] != rptr_r[RXF_AW]);
  assign head_s  = empty_s ? 8'h00 : fifo_mem_r[rptr_r[RXF_AW-1:0]];

  assign rcsr_wr_s = sel & wr & (addr == 2'd0);
  assign xcsr_wr_s = sel & wr & (addr == 2'd2);
  assign xbuf_wr_s = sel & wr & (addr == 2'd3);
  assign rbuf_rd_s = sel & rd & (addr == 2'd1);
  assign pop_s     = rbuf_rd_s & ~empty_s;

  // The acknowledge occupies one cycle. serial_rx drops rx_ready in response,
  // so masking by last cycle's rx_read stops a byte from being taken twice.
  assign capture_s = rx_ready & ~rx_read_r;
  // A pop on the same cycle frees the slot that the push needs.
  assign push_s    = capture_s & (~full_s | pop_s);
  assign overrun_s = capture_s & full_s & ~pop_s;

  assign unused_bits_s = ^wdata[15:8];

  // Register read mux
  always_comb begin
    rdata = 16'h0000;
    case (addr)
      2'd0:    rdata = {8'h00, ~empty_s, rie_r, 6'b000000};
      2'd1:    rdata = {ovr_r, ovr_r, 6'b000000, head_s};
      2'd2:    rdata = {8'h00, xready_r, xie_r, 6'b000000};
      2'd3:    rdata = 16'h0000;
      default: rdata = 16'h0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wptr_r <= {(RXF_AW + 1){1'b0}};
      rptr_r <= {(RXF_AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wptr_r[RXF_AW-1:0]] <= rx_byte;
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

  // Acknowledge pulse and sticky overrun flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_read_r <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      rx_read_r <= capture_s;
      if (overrun_s) begin
        ovr_r <= 1'b1;
      end else if (rbuf_rd_s) begin
        // Any RBUF read clears overrun, even with the FIFO empty.
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers and transmit buffer
  // ---------------------------------------------------------------------------

  // Interrupt enables
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rie_r <= 1'b0;
      xie_r <= 1'b0;
    end else begin
      if (rcsr_wr_s) begin
        rie_r <= wdata[6];
      end
      if (xcsr_wr_s) begin
        xie_r <= wdata[6];
      end
    end
  end

  // Transmit holding buffer, XREADY and byte-pending flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xbuf_r    <= 8'h00;
      xready_r  <= 1'b1;
      pending_r <= 1'b0;
    end else begin
      if (xbuf_wr_s && xready_r) begin
        xbuf_r    <= wdata[7:0];
        xready_r  <= 1'b0;
        pending_r <= 1'b1;
      end else if ((state_r == WAITD) && !tx_busy) begin
        xready_r <= 1'b1;
      end else if (state_r == SEND) begin
        pending_r <= 1'b0;
      end else begin
        xready_r  <= xready_r;
        pending_r <= pending_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit sequencer
  // ---------------------------------------------------------------------------

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!xready_r && pending_r) begin
          next_state_s = SEND;
        end else begin
          next_state_s = IDLE;
        end
      end
      SEND: next_state_s = WAITB;
      WAITB: begin
        if (tx_busy) begin
          next_state_s = WAITD;
        end else begin
          next_state_s = WAITB;
        end
      end
      WAITD: begin
        if (!tx_busy) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAITD;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // The start pulse and byte are registered from next state, so they are
  // valid exactly while the sequencer sits in SEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_send_r <= 1'b0;
      tx_byte_r <= 8'h00;
    end else begin
      tx_send_r <= (next_state_s == SEND);
      if (next_state_s == SEND) begin
        tx_byte_r <= xbuf_r;
      end
    end
  end

  // Interrupt requests, one cycle behind their sources
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_irq_r <= 1'b0;
      tx_irq_r <= 1'b0;
    end else begin
      rx_irq_r <= rie_r & ~empty_s;
      tx_irq_r <= xie_r & xready_r;
    end
  end

  assign rx_read = rx_read_r;
  assign tx_send = tx_send_r;
  assign tx_byte = tx_byte_r;
  assign rx_irq  = rx_irq_r;
  assign tx_irq  = tx_irq_r;

endmodule

// File: tb/tb_serial_dl11.sv
// Self-checking bench for serial_dl11. Expected RBUF contents and expected
// transmit bytes are queued by the bench as stimulus is driven and compared
// when the DUT produces them.
module tb_serial_dl11;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        wr;
  logic        rd;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        rx_read;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_busy;
  logic        rx_irq;
  logic        tx_irq;

  int n_tests;
  int n_fail;
  int rx_read_cnt;
  int tx_send_cnt;

  logic [7:0] rx_q[$];
  logic       exp_ovr;
  logic [7:0] tx_q[$];

  serial_dl11 #(.RXF_AW(2)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .wr(wr), .rd(rd),
    .wdata(wdata), .rdata(rdata), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .rx_read(rx_read), .tx_byte(tx_byte), .tx_send(tx_send),
    .tx_busy(tx_busy), .rx_irq(rx_irq), .tx_irq(tx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_read === 1'b1) rx_read_cnt++;
    if (tx_send === 1'b1) tx_send_cnt++;
  end

  // Reference model of an RBUF read: value seen, then pop and clear OVR.
  function automatic logic [15:0] model_rbuf_rd();
    logic [7:0] h;
    h = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    model_rbuf_rd = {exp_ovr, exp_ovr, 6'b000000, h};
    if (rx_q.size() > 0) void'(rx_q.pop_front());
    exp_ovr = 1'b0;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (rx_q.size() < 4) rx_q.push_back(b);
    else exp_ovr = 1'b1;
  endfunction

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0; wdata = 16'h0000;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    sel = 1'b0; rd = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [15:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  // serial_rx model: present a byte, hold until acknowledged (bounded).
  task automatic send_rx(input logic [7:0] b, output logic ok);
    @(negedge clk);
    rx_byte = b; rx_ready = 1'b1; ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rx_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    rx_ready = 1'b0;
    if (ok) model_push(b);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    peek(2'd0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_rcsr: got %h expected %h", d, 16'h0000); end
    peek(2'd2, d);
    n_tests++; if (d !== 16'h0080) begin n_fail++; $display("FAIL reset_xcsr: got %h expected %h", d, 16'h0080); end
    n_tests++; if ({rx_irq, tx_irq, rx_read, tx_send} !== 4'b0000) begin n_fail++; $display("FAIL reset_outs: got %b expected 0000", {rx_irq, tx_irq, rx_read, tx_send}); end
    n_tests++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
  endtask

  task automatic test_rx_single();
    logic [15:0] d, e;
    logic ok;
    int c0;
    c0 = rx_read_cnt;
    send_rx(8'h41, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rx1_ack: got no rx_read expected pulse"); end
    repeat (3) @(negedge clk);
    n_tests++; if (rx_read_cnt - c0 != 1) begin n_fail++; $display("FAIL rx1_pulses: got %0d expected 1", rx_read_cnt - c0); end
    peek(2'd0, d);
    n_tests++; if (d !== 16'h0080) begin n_fail++; $display("FAIL rx1_rcsr: got %h expected %h", d, 16'h0080); end
    bus_wr(2'd0, 16'h0040);
    repeat (2) @(negedge clk);
    n_tests++; if (rx_irq !== 1'b1) begin n_fail++; $display("FAIL rx1_irq_on: got %b expected 1", rx_irq); end
    bus_rd(2'd1, d);
    e = model_rbuf_rd();
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL rx1_rbuf: got %h expected %h", d, e); end
    peek(2'd0, d);
    n_tests++; if (d !== 16'h0040) begin n_fail++; $display("FAIL rx1_rcsr_after: got %h expected %h", d, 16'h0040); end
    repeat (2) @(negedge clk);
    n_tests++; if (rx_irq !== 1'b0) begin n_fail++; $display("FAIL rx1_irq_off: got %b expected 0", rx_irq); end
    bus_wr(2'd0, 16'h0000);
  endtask

  task automatic test_overrun();
    logic [15:0] d, e;
    logic ok;
    for (int i = 1; i <= 5; i++) begin
      send_rx(i[7:0], ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL ovr_ack%0d: got no rx_read expected pulse", i); end
    end
    for (int i = 0; i < 4; i++) begin
      bus_rd(2'd1, d);
      e = model_rbuf_rd();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL ovr_rbuf%0d: got %h expected %h", i, d, e); end
    end
    peek(2'd0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL ovr_rcsr_empty: got %h expected %h", d, 16'h0000); end
  endtask

  task automatic test_tx();
    logic [15:0] d;
    logic [7:0] eb;
    logic seen;
    int c0;
    c0 = tx_send_cnt;
    bus_wr(2'd2, 16'h0040);
    bus_wr(2'd3, 16'h005A);
    tx_q.push_back(8'h5A);
    peek(2'd2, d);
    n_tests++; if (d !== 16'h0040) begin n_fail++; $display("FAIL tx_xcsr_busy: got %h expected %h", d, 16'h0040); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_send === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL tx_send_timeout: got no tx_send expected pulse"); end
    if (seen) begin
      eb = tx_q.pop_front();
      n_tests++; if (tx_byte !== eb) begin n_fail++; $display("FAIL tx_byte: got %h expected %h", tx_byte, eb); end
      n_tests++; if (tx_irq !== 1'b0) begin n_fail++; $display("FAIL tx_irq_low: got %b expected 0", tx_irq); end
    end
    @(negedge clk);
    tx_busy = 1'b1;
    bus_wr(2'd3, 16'h00A5);
    peek(2'd2, d);
    n_tests++; if (d !== 16'h0040) begin n_fail++; $display("FAIL tx_xcsr_during: got %h expected %h", d, 16'h0040); end
    repeat (4) @(negedge clk);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    peek(2'd2, d);
    n_tests++; if (d !== 16'h00C0) begin n_fail++; $display("FAIL tx_xcsr_done: got %h expected %h", d, 16'h00C0); end
    n_tests++; if (tx_irq !== 1'b1) begin n_fail++; $display("FAIL tx_irq_high: got %b expected 1", tx_irq); end
    n_tests++; if (tx_send_cnt - c0 != 1) begin n_fail++; $display("FAIL tx_send_count: got %0d expected 1", tx_send_cnt - c0); end
    n_tests++; if (tx_byte !== 8'h5A) begin n_fail++; $display("FAIL tx_byte_hold: got %h expected 5a", tx_byte); end
  endtask

  task automatic test_full_simul();
    logic [15:0] d, e;
    logic ok;
    for (int i = 0; i < 4; i++) begin
      send_rx(8'h10 + i[7:0], ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL full_ack%0d: got no rx_read expected pulse", i); end
    end
    // Capture of 0x14 and RBUF pop land on the same clock edge.
    @(negedge clk);
    rx_byte = 8'h14; rx_ready = 1'b1;
    sel = 1'b1; rd = 1'b1; addr = 2'd1;
    #1 d = rdata;
    e = model_rbuf_rd();
    model_push(8'h14);
    @(negedge clk);
    sel = 1'b0; rd = 1'b0;
    n_tests++; if (rx_read !== 1'b1) begin n_fail++; $display("FAIL full_ack_simul: got %b expected 1", rx_read); end
    rx_ready = 1'b0;
    n_tests++; if (d !== e) begin n_fail++; $display("FAIL full_simul_rbuf: got %h expected %h", d, e); end
    for (int i = 0; i < 4; i++) begin
      bus_rd(2'd1, d);
      e = model_rbuf_rd();
      n_tests++; if (d !== e) begin n_fail++; $display("FAIL full_drain%0d: got %h expected %h", i, d, e); end
    end
    peek(2'd0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL full_rcsr_empty: got %h expected %h", d, 16'h0000); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d, e;
    logic ok, seen;
    int c0;
    bus_wr(2'd0, 16'h0040);
    send_rx(8'h99, ok);
    bus_wr(2'd3, 16'h0077);
    tx_q.push_back(8'h77);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_send === 1'b1) begin seen = 1'b1; break; end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL mid_send_timeout: got no tx_send expected pulse"); end
    n_tests++; if (rx_irq !== 1'b1) begin n_fail++; $display("FAIL mid_irq_pre: got %b expected 1", rx_irq); end
    @(negedge clk);
    // Sequencer now waiting for tx_busy; reset with a byte pending on rx.
    rx_byte = 8'h3C; rx_ready = 1'b1;
    reset = 1'b0;
    rx_q.delete(); exp_ovr = 1'b0; tx_q.delete();
    #1;
    n_tests++; if ({rx_irq, tx_irq, rx_read, tx_send} !== 4'b0000) begin n_fail++; $display("FAIL mid_outs: got %b expected 0000", {rx_irq, tx_irq, rx_read, tx_send}); end
    n_tests++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL mid_tx_byte: got %h expected 00", tx_byte); end
    peek(2'd2, d);
    n_tests++; if (d !== 16'h0080) begin n_fail++; $display("FAIL mid_xcsr: got %h expected %h", d, 16'h0080); end
    peek(2'd0, d);
    n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL mid_rcsr: got %h expected %h", d, 16'h0000); end
    repeat (2) @(negedge clk);
    c0 = rx_read_cnt;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rx_read === 1'b1) begin seen = 1'b1; break; end
    end
    rx_ready = 1'b0;
    if (seen) model_push(8'h3C);
    repeat (3) @(negedge clk);
    n_tests++; if (rx_read_cnt - c0 != 1) begin n_fail++; $display("FAIL mid_capture_once: got %0d expected 1", rx_read_cnt - c0); end
    bus_rd(2'd1, d);
    e = model_rbuf_rd();
    n_tests++; if (d !== 16'h003C || d !== e) begin n_fail++; $display("FAIL mid_rbuf: got %h expected %h", d, 16'h003C); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; rx_read_cnt = 0; tx_send_cnt = 0;
    exp_ovr = 1'b0;
    reset = 1'b0; sel = 1'b0; addr = 2'd0; wr = 1'b0; rd = 1'b0;
    wdata = 16'h0000; rx_byte = 8'h00; rx_ready = 1'b0; tx_busy = 1'b0;
    test_reset();
    test_rx_single();
    test_overrun();
    test_tx();
    test_full_simul();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
